// File: rtl/conv_window_gen_pkg.sv
// Shared constants and helpers for the conv-layer window generator and calc stage.
package conv_window_gen_pkg;

    // Bit k set when KERNEL=k is a supported window side (1, 3, 5, 7).
    localparam logic [7:0] KERNEL_LEGAL = 8'b1010_1010;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < value) w = w + 1;
        return w;
    endfunction

    function automatic int unsigned slot_ofs(input int unsigned slot, input int unsigned n);
        return slot * n;
    endfunction

    function automatic bit kernel_is_legal(input int unsigned k);
        logic [2:0] idx;
        idx = k[2:0];
        return (k < 8) && KERNEL_LEGAL[idx];
    endfunction

endpackage

// File: rtl/conv_window_gen_line_delay.sv
// One image line of delay: output is the pixel accepted DEPTH enables ago.
module conv_window_gen_line_delay #(
    parameter int DEPTH = 8,
    parameter int N     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [N-1:0] i_din,
    output logic [N-1:0] o_dout
);

    logic [N-1:0] r_sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else if (i_en) begin
            r_sr[0] <= i_din;
            for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_dout = r_sr[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// KERNEL x KERNEL sliding-window generator feeding the conv-layer calc stage.
// Define WIN_LAST_EN to add the win_last end-of-frame window flag.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               pix_in,
    input  logic                       en_in,
    input  logic                       sof,
    output logic [KERNEL*KERNEL*N-1:0] data2conv,
    output logic                       en_out
`ifdef WIN_LAST_EN
    ,
    output logic                       win_last
`endif
);

    localparam int unsigned CW = clog2(IMG_W);
    localparam int unsigned RW = clog2(IMG_H);
    localparam int unsigned KH = (KERNEL > 1) ? KERNEL - 1 : 1;
    localparam int unsigned WB = KERNEL * KERNEL * N;
    localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);

    if (!kernel_is_legal(KERNEL) || IMG_W < KERNEL || IMG_H < KERNEL) begin : g_param_check
        $error("conv_window_gen: illegal KERNEL/IMG_W/IMG_H combination");
    end

    logic [CW-1:0] r_col;
    logic [CW-1:0] w_col;
    logic [RW-1:0] r_row;
    logic [RW-1:0] w_row;
    logic          w_valid;
    logic [N-1:0]  w_tap [KERNEL];
    logic [N-1:0]  r_win [KERNEL][KH];
    logic [WB-1:0] w_window;
    logic [WB-1:0] r_data;
    logic          r_en_out;

    // sof overrides the counters for the current pixel only; buffers keep stale lines.
    assign w_col   = sof ? '0 : r_col;
    assign w_row   = sof ? '0 : r_row;
    assign w_valid = en_in && (w_row >= ROW_FIRST) && (w_col >= COL_FIRST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (en_in) begin
            if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    assign w_tap[KERNEL-1] = pix_in;

    for (genvar j = 0; j < KERNEL - 1; j++) begin : g_line
        logic [N-1:0] w_line_in;
        logic [N-1:0] w_line_out;

        if (j == 0) begin : g_head
            assign w_line_in = pix_in;
        end else begin : g_chain
            assign w_line_in = g_line[j-1].w_line_out;
        end

        conv_window_gen_line_delay #(
            .DEPTH (IMG_W),
            .N     (N)
        ) u_line (
            .clk    (clk),
            .rst    (rst),
            .i_en   (en_in),
            .i_din  (w_line_in),
            .o_dout (w_line_out)
        );

        assign w_tap[KERNEL-2-j] = w_line_out;
    end

    // Per-row shift of the KERNEL-1 older columns; the newest column is the live tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < KERNEL; r++)
                for (int unsigned c = 0; c < KH; c++) r_win[r][c] <= '0;
        end else if (en_in) begin
            for (int unsigned r = 0; r < KERNEL; r++) begin
                for (int unsigned c = 0; c + 1 < KH; c++) r_win[r][c] <= r_win[r][c+1];
                r_win[r][KH-1] <= w_tap[r];
            end
        end
    end

    always_comb begin
        w_window = '0;
        for (int unsigned r = 0; r < KERNEL; r++) begin
            for (int unsigned c = 0; c + 1 < KERNEL; c++)
                w_window[slot_ofs(r*KERNEL + c, N) +: N] = r_win[r][c];
            w_window[slot_ofs(r*KERNEL + KERNEL - 1, N) +: N] = w_tap[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_en_out <= 1'b0;
        end else begin
            r_en_out <= w_valid;
            if (w_valid) r_data <= w_window;
        end
    end

    assign data2conv = r_data;
    assign en_out    = r_en_out;

`ifdef WIN_LAST_EN
    logic r_win_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_win_last <= 1'b0;
        else     r_win_last <= w_valid && (w_row == ROW_LAST) && (w_col == COL_LAST);
    end

    assign win_last = r_win_last;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed self-checking bench for conv_window_gen (KERNEL=3, N=8, 8x8 image).
module tb_conv_window_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_in;
    logic        sof;
    logic [7:0]  pix_in;
    logic [71:0] data2conv;
    logic        en_out;
`ifdef WIN_LAST_EN
    logic        win_last;
`endif

    int total = 0;
    int bad   = 0;
    logic [71:0] exp_d;

    always #5 clk = ~clk;

    conv_window_gen #(
        .KERNEL (3),
        .N      (8),
        .IMG_W  (8),
        .IMG_H  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .en_in     (en_in),
        .sof       (sof),
        .data2conv (data2conv),
        .en_out    (en_out)
`ifdef WIN_LAST_EN
        ,
        .win_last  (win_last)
`endif
    );

    // Window whose bottom-right pixel is (r,c) in a frame of values base + row*8 + col.
    function automatic logic [71:0] exp_win(input int base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                w[(rr*3+cc)*8 +: 8] = 8'(base + (r - 2 + rr) * 8 + (c - 2 + cc));
        return w;
    endfunction

    task automatic step(input logic e, input logic [7:0] p, input logic s);
        en_in  = e;
        pix_in = p;
        sof    = s;
        @(posedge clk);
        #1;
        en_in = 1'b0;
        sof   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(logic'(i % 2), 8'(i * 37 + 5), 1'b0);
            total++;
            if (en_out !== 1'b0) begin
                bad++;
                $display("FAIL reset_en_out: got=%b want=0", en_out);
            end
            total++;
            if (data2conv !== 72'h0) begin
                bad++;
                $display("FAIL reset_data: got=%h want=0", data2conv);
            end
        end
        rst   = 1'b0;
        exp_d = '0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 8'hFF, 1'b0);
            total++;
            if (en_out !== 1'b0 || data2conv !== 72'h0) begin
                bad++;
                $display("FAIL post_reset_idle: got en_out=%b data=%h want 0/0", en_out, data2conv);
            end
        end
    endtask

    task automatic test_full_frame;
        int r, c, wins;
        logic v;
        logic [71:0] first;
        int slots[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        first = '0;
        for (int s = 0; s < 9; s++) first[s*8 +: 8] = 8'(slots[s]);
        wins = 0;
        for (int i = 0; i < 64; i++) begin
            r = i / 8;
            c = i % 8;
            step(1'b1, 8'(i), i == 0);
            v = (r >= 2 && c >= 2);
            if (v) exp_d = exp_win(0, r, c);
            if (en_out === 1'b1) wins++;
            total++;
            if (en_out !== v) begin
                bad++;
                $display("FAIL full_en_out(%0d,%0d): got=%b want=%b", r, c, en_out, v);
            end
            total++;
            if (data2conv !== exp_d) begin
                bad++;
                $display("FAIL full_data(%0d,%0d): got=%h want=%h", r, c, data2conv, exp_d);
            end
`ifdef WIN_LAST_EN
            total++;
            if (win_last !== (v && r == 7 && c == 7)) begin
                bad++;
                $display("FAIL full_win_last(%0d,%0d): got=%b", r, c, win_last);
            end
`endif
            if (i == 18) begin
                total++;
                if (data2conv !== first) begin
                    bad++;
                    $display("FAIL first_window: got=%h want=%h", data2conv, first);
                end
            end
        end
        total++;
        if (wins !== 36) begin
            bad++;
            $display("FAIL full_win_count: got=%0d want=36", wins);
        end
    endtask

    task automatic test_gaps;
        int r, c, wins, gap;
        logic v;
        wins = 0;
        for (int i = 0; i < 64; i++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 8'($urandom), 1'b0);
                total++;
                if (en_out !== 1'b0 || data2conv !== exp_d) begin
                    bad++;
                    $display("FAIL gap_hold: got en_out=%b data=%h want 0/%h", en_out, data2conv, exp_d);
                end
            end
            r = i / 8;
            c = i % 8;
            step(1'b1, 8'(i), 1'b0);
            v = (r >= 2 && c >= 2);
            if (v) exp_d = exp_win(0, r, c);
            if (en_out === 1'b1) wins++;
            total++;
            if (en_out !== v || data2conv !== exp_d) begin
                bad++;
                $display("FAIL gap_window(%0d,%0d): got %b/%h want %b/%h", r, c, en_out, data2conv, v, exp_d);
            end
        end
        total++;
        if (wins !== 36) begin
            bad++;
            $display("FAIL gap_win_count: got=%0d want=36", wins);
        end
    endtask

    task automatic test_sof_restart;
        int r, c, wins;
        logic v;
        for (int i = 0; i < 27; i++) begin
            r = i / 8;
            c = i % 8;
            step(1'b1, 8'(i), 1'b0);
            v = (r >= 2 && c >= 2);
            if (v) exp_d = exp_win(0, r, c);
            total++;
            if (en_out !== v || data2conv !== exp_d) begin
                bad++;
                $display("FAIL sof_frame_a(%0d,%0d): got %b/%h want %b/%h", r, c, en_out, data2conv, v, exp_d);
            end
        end
        wins = 0;
        for (int i = 0; i < 64; i++) begin
            r = i / 8;
            c = i % 8;
            step(1'b1, 8'(100 + i), i == 0);
            v = (r >= 2 && c >= 2);
            if (v) exp_d = exp_win(100, r, c);
            if (en_out === 1'b1) wins++;
            total++;
            if (en_out !== v || data2conv !== exp_d) begin
                bad++;
                $display("FAIL sof_frame_b(%0d,%0d): got %b/%h want %b/%h", r, c, en_out, data2conv, v, exp_d);
            end
        end
        total++;
        if (wins !== 36) begin
            bad++;
            $display("FAIL sof_win_count: got=%0d want=36", wins);
        end
    endtask

    task automatic test_mid_reset;
        int r, c, wins;
        logic v;
        for (int i = 0; i <= 40; i++) begin
            r = i / 8;
            c = i % 8;
            step(1'b1, 8'(i), 1'b0);
            v = (r >= 2 && c >= 2);
            if (v) exp_d = exp_win(0, r, c);
            total++;
            if (en_out !== v || data2conv !== exp_d) begin
                bad++;
                $display("FAIL pre_reset(%0d,%0d): got %b/%h want %b/%h", r, c, en_out, data2conv, v, exp_d);
            end
        end
        rst    = 1'b1;
        en_in  = 1'b1;
        pix_in = 8'd41;
        #1;
        total++;
        if (en_out !== 1'b0 || data2conv !== 72'h0) begin
            bad++;
            $display("FAIL async_reset: got en_out=%b data=%h want 0/0", en_out, data2conv);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        en_in = 1'b0;
        exp_d = '0;
        wins  = 0;
        for (int i = 0; i < 64; i++) begin
            r = i / 8;
            c = i % 8;
            step(1'b1, 8'(100 + i), 1'b0);
            v = (r >= 2 && c >= 2);
            if (v) exp_d = exp_win(100, r, c);
            if (en_out === 1'b1) wins++;
            total++;
            if (en_out !== v || data2conv !== exp_d) begin
                bad++;
                $display("FAIL post_reset(%0d,%0d): got %b/%h want %b/%h", r, c, en_out, data2conv, v, exp_d);
            end
        end
        total++;
        if (wins !== 36) begin
            bad++;
            $display("FAIL post_reset_win_count: got=%0d want=36", wins);
        end
    endtask

    task automatic test_back_to_back;
        int r, c, wins, lasts, base;
        logic v;
        wins  = 0;
        lasts = 0;
        for (int f = 0; f < 2; f++) begin
            base = (f == 0) ? 0 : 100;
            for (int i = 0; i < 64; i++) begin
                r = i / 8;
                c = i % 8;
                step(1'b1, 8'(base + i), 1'b0);
                v = (r >= 2 && c >= 2);
                if (v) exp_d = exp_win(base, r, c);
                if (en_out === 1'b1) wins++;
                total++;
                if (en_out !== v || data2conv !== exp_d) begin
                    bad++;
                    $display("FAIL b2b(%0d:%0d,%0d): got %b/%h want %b/%h", f, r, c, en_out, data2conv, v, exp_d);
                end
`ifdef WIN_LAST_EN
                if (win_last === 1'b1) lasts++;
                total++;
                if (win_last !== (v && r == 7 && c == 7)) begin
                    bad++;
                    $display("FAIL b2b_win_last(%0d:%0d,%0d): got=%b at window %0d", f, r, c, win_last, wins);
                end
`endif
            end
        end
        total++;
        if (wins !== 72) begin
            bad++;
            $display("FAIL b2b_win_count: got=%0d want=72", wins);
        end
`ifdef WIN_LAST_EN
        total++;
        if (lasts !== 2) begin
            bad++;
            $display("FAIL b2b_last_count: got=%0d want=2", lasts);
        end
`endif
    endtask

    initial begin
        rst    = 1'b1;
        en_in  = 1'b0;
        sof    = 1'b0;
        pix_in = '0;
        exp_d  = '0;
        test_reset();
        test_full_frame();
        test_gaps();
        test_sof_restart();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
